lmc_prog_loader: RTL

// - Serial program loader: writer end of the 16x8 program RAM that the counter/fetch block reads.
// - Receives a bit-serial stream from the front panel, assembles bytes and writes them to RAM

---
 rtl/lmc_prog_loader_if.sv | 34 +++
 rtl/lmc_prog_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lmc_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lmc_prog_loader_if
// Description : Front-panel serial input and RAM write-port bundle for the
//               LMC program loader. The master drives start/serial bits and
//               observes the RAM port; the slave is the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface lmc_prog_loader_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  ser_valid;
    logic                  ser_bit;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;
    logic                  busy;
    logic                  hold_cpu;
    logic                  done;
    logic                  err;

    modport master (
        output start, ser_valid, ser_bit,
        input  ram_addr, ram_wdata, ram_we, busy, hold_cpu, done, err
    );

    modport slave (
        input  start, ser_valid, ser_bit,
        output ram_addr, ram_wdata, ram_we, busy, hold_cpu, done, err
    );
endinterface
`default_nettype wire

// File: rtl/lmc_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : lmc_prog_loader
// Description : Bit-serial program loader for the 16x8 LMC program RAM.
//               Assembles LSB-first bytes, parses a LEN header and writes the
//               data bytes from address 0 upward while holding the CPU.
//               Optional trailing checksum byte: define LMC_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lmc_prog_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input wire               clk,
    input wire               reset_count,
    lmc_prog_loader_if.slave bus
);
    localparam int c_BITCNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BITCNT_W-1:0] c_LAST_BIT  = c_BITCNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
    localparam logic [DATA_WIDTH:0]   c_DEPTH_CMP = (DATA_WIDTH + 1)'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_WR   = 3'd3,
`ifdef LMC_LOADER_CHECKSUM_EN
        S_CHK  = 3'd4,
`endif
        S_DONE = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [c_BITCNT_W-1:0]   r_bitcnt;
    logic [DATA_WIDTH-2:0]   r_shift;     // upper bits of the byte being assembled
    logic [ADDR_WIDTH:0]     r_remain;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_done;
    logic                    r_err;

    logic [DATA_WIDTH-1:0]   w_byte;      // byte as it would look with this cycle's bit
    logic [ADDR_WIDTH:0]     w_len;
    logic                    w_capture;
    logic                    w_byte_done;
    logic                    w_len_bad;
    logic                    w_busy;
    logic                    w_start_acc;
    logic                    w_hdr_load;
    logic                    w_data_load;
    logic                    w_wr_exit;
    logic                    w_err_set;

    // Serial bits are only meaningful while waiting for a header, data or checksum byte.
`ifdef LMC_LOADER_CHECKSUM_EN
    assign w_capture = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
    assign w_busy    = (r_state == S_HDR) || (r_state == S_DATA) ||
                       (r_state == S_WR)  || (r_state == S_CHK);
`else
    assign w_capture = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_busy    = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WR);
`endif

    assign w_byte      = {bus.ser_bit, r_shift};
    assign w_byte_done = w_capture && bus.ser_valid && (r_bitcnt == c_LAST_BIT);
    assign w_len_bad   = ({1'b0, w_byte} > c_DEPTH_CMP);
    // A zero header means a full RAM image.
    assign w_len       = (w_byte == '0) ? c_DEPTH : (ADDR_WIDTH + 1)'(w_byte);

`ifdef LMC_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  w_chk_bad;

    assign w_chk_bad = (w_byte != r_sum);

    // Running mod-256 sum of the data bytes, restarted by each accepted start.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_sum <= '0;
        end else if (w_start_acc) begin
            r_sum <= '0;
        end else if (w_data_load) begin
            r_sum <= r_sum + w_byte;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_nx  = r_state;
        w_start_acc = 1'b0;
        w_hdr_load  = 1'b0;
        w_data_load = 1'b0;
        w_wr_exit   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nx  = S_HDR;
                end
            end
            S_HDR: begin
                if (w_byte_done) begin
                    if (w_len_bad) begin
                        w_err_set  = 1'b1;
                        w_state_nx = S_DONE;
                    end else begin
                        w_hdr_load = 1'b1;
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_byte_done) begin
                    w_data_load = 1'b1;
                    w_state_nx  = S_WR;
                end
            end
            S_WR: begin
                // The write strobe always completes; a bit arriving now is a sender fault.
                w_wr_exit = 1'b1;
                if (bus.ser_valid) begin
                    w_err_set  = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_remain == (ADDR_WIDTH + 1)'(1)) begin
`ifdef LMC_LOADER_CHECKSUM_EN
                    w_state_nx = S_CHK;
`else
                    w_state_nx = S_DONE;
`endif
                end else begin
                    w_state_nx = S_DATA;
                end
            end
`ifdef LMC_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_byte_done) begin
                    w_err_set  = w_chk_bad;
                    w_state_nx = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Bit assembly: shift right with the new bit entering at the MSB.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (w_start_acc) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (w_capture && bus.ser_valid) begin
            r_shift  <= w_byte[DATA_WIDTH-1:1];
            r_bitcnt <= (r_bitcnt == c_LAST_BIT) ? '0 : r_bitcnt + 1'b1;
        end
    end

    // Write address, data, remaining count and the sticky status flags.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_addr <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_hdr_load) begin
                r_remain <= w_len;
            end
            if (w_data_load) begin
                r_wdata <= w_byte;
            end
            if (w_wr_exit) begin
                r_addr   <= r_addr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_state_nx == S_DONE) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;
    assign bus.ram_we    = (r_state == S_WR);
    assign bus.busy      = w_busy;
    assign bus.hold_cpu  = w_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
